// File: rtl/pattern_match_ctrl_pkg.sv
// Shared types and default widths for the programmable serial pattern matcher.
package pmc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READY = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_TARGET  = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_ABORT   = 2'b11
  } status_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TO_W    = 16;

endpackage

// File: rtl/pattern_match_ctrl_if.sv
// Configuration channel: valid/ready handshake carrying pattern, length, target and timeout.
interface pattern_match_ctrl_if #(
  parameter int MAX_LEN = pmc_pkg::DEF_MAX_LEN,
  parameter int CNT_W   = pmc_pkg::DEF_CNT_W,
  parameter int TO_W    = pmc_pkg::DEF_TO_W
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic [TO_W-1:0]    cfg_timeout;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_timeout,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/pattern_match_ctrl_matcher.sv
// Serial history shift register with saturating fill count and a length-masked compare.
// hit reflects the history as it will be after the current bit is shifted in.
module pattern_shift_matcher #(
  parameter int MAX_LEN = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             shift_en,
  input  logic                             sbit,
  input  logic [MAX_LEN-1:0]               pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]     len,
  output logic                             hit
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] hist, hist_new, mask;
  logic [LEN_W-1:0]   seen, seen_new;

  always_comb begin
    hist_new = {hist[MAX_LEN-2:0], sbit};
    seen_new = (seen == LEN_W'(MAX_LEN)) ? seen : seen + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
    hit = shift_en && (seen_new >= len) && ((hist_new & mask) == (pattern & mask));
  end

  // NOTE: registers use non-blocking assignments so every flop updates together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      seen <= '0;
    end else if (clear) begin
      hist <= '0;
      seen <= '0;
    end else if (shift_en) begin
      hist <= hist_new;
      seen <= seen_new;
    end
  end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Configures, arms and sequences the serial pattern matcher; stops on target,
// timeout or abort and reports a completion status.
module pattern_match_ctrl
  import pmc_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic                 clk,
  input  logic                 reset,
  pattern_match_ctrl_if.slave  cfg,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ip_valid,
  input  logic                 ip,
  output logic                 match,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status,
  output logic [CNT_W-1:0]     match_count
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t             state, state_next;
  status_t            status_q, exit_st;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tgt_q, count_inc;
  logic [TO_W-1:0]    to_q, timer;
  logic               err_q, hs, len_ok, clear, run, hit, hit_ok, target_hit, to_hit;

  assign cfg.cfg_ready = (state == IDLE) || (state == READY);
  assign cfg.cfg_err   = err_q;
  assign hs            = cfg.cfg_valid && cfg.cfg_ready;
  assign len_ok        = (cfg.cfg_len != '0) && (cfg.cfg_len <= LEN_W'(MAX_LEN));
  assign run           = (state == RUN);
  assign busy          = run;
  assign done          = (state == DONE);
  assign status        = status_q;

  // An aborting edge discards any match completed by the same bit.
  assign hit_ok     = hit && !abort;
  assign count_inc  = (&match_count) ? match_count : match_count + CNT_W'(1);
  assign target_hit = (tgt_q != '0) && hit && (count_inc == tgt_q);
  assign to_hit     = (to_q != '0) && (timer == to_q - TO_W'(1));

  pattern_shift_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift_en (run && ip_valid),
    .sbit     (ip),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    exit_st    = ST_NONE;
    unique case (state)
      IDLE:  if (hs) state_next = len_ok ? READY : IDLE;
      READY: begin
        if (hs) begin
          state_next = len_ok ? READY : IDLE;
        end else if (start) begin
          state_next = RUN;
          clear      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = DONE;
          exit_st    = ST_ABORT;
        end else if (target_hit) begin
          state_next = DONE;
          exit_st    = ST_TARGET;
        end else if (to_hit) begin
          state_next = DONE;
          exit_st    = ST_TIMEOUT;
        end
      end
      DONE:  state_next = READY;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q       <= '0;
      len_q       <= '0;
      tgt_q       <= '0;
      to_q        <= '0;
      err_q       <= 1'b0;
      timer       <= '0;
      match_count <= '0;
      match       <= 1'b0;
      status_q    <= ST_NONE;
    end else begin
      match <= hit_ok;
      if (hs) begin
        pat_q <= cfg.cfg_pattern;
        len_q <= cfg.cfg_len;
        tgt_q <= cfg.cfg_target;
        to_q  <= cfg.cfg_timeout;
        err_q <= !len_ok;
      end
      if (clear) begin
        timer       <= '0;
        match_count <= '0;
        status_q    <= ST_NONE;
      end else if (run) begin
        timer <= timer + TO_W'(1);
        if (hit_ok) match_count <= count_inc;
        if (state_next == DONE) status_q <= exit_st;
      end
    end
  end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Directed bench for pattern_match_ctrl: stimulus pushes expected match/done events
// with their cycle stamp; a negedge monitor pops and compares them.
module tb_pattern_match_ctrl;
  import pmc_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, abort, ip_valid, ip;
  logic             match, busy, done;
  logic [1:0]       status;
  logic [CNT_W-1:0] match_count;

  pattern_match_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_W(TO_W)) cfg_if ();

  pattern_match_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg         (cfg_if.slave),
    .start       (start),
    .abort       (abort),
    .ip_valid    (ip_valid),
    .ip          (ip),
    .match       (match),
    .busy        (busy),
    .done        (done),
    .status      (status),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_done;
    int         cyc;
    logic [1:0] st;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Scenario-2 stream (first bit first) and the hand-computed match count after each bit.
  int s2_bits[7] = '{1, 0, 1, 0, 1, 0, 1};
  int s2_mcnt[7] = '{0, 0, 0, 0, 1, 0, 2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input logic is_done);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_unexpected: DUT raised %s at cycle %0d, none expected",
               is_done ? "done" : "match", cyc);
    end else begin
      e = q.pop_front();
      check(is_done ? "sb_done_kind" : "sb_match_kind", 32'(is_done), 32'(e.is_done));
      check("sb_cycle", cyc, e.cyc);
      check("sb_count", 32'(match_count), e.cnt);
      if (is_done) begin
        check("sb_status", 32'(status), 32'(e.st));
        check("sb_busy_in_done", 32'(busy), 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (match) pop_check(1'b0);
      if (done)  pop_check(1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [MAX_LEN-1:0] pat, input logic [3:0] len,
                           input logic [CNT_W-1:0] tgt, input logic [TO_W-1:0] to,
                           input logic exp_err);
    cfg_if.cfg_pattern = pat;
    cfg_if.cfg_len     = len;
    cfg_if.cfg_target  = tgt;
    cfg_if.cfg_timeout = to;
    cfg_if.cfg_valid   = 1'b1;
    check("cfg_ready_pre", 32'(cfg_if.cfg_ready), 32'd1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("cfg_err", 32'(cfg_if.cfg_err), 32'(exp_err));
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_run", 32'(busy), 32'd1);
  endtask

  // One input cycle; expected events appear at the monitor in the following cycle.
  task automatic drive(input logic v, input logic b, input logic ab,
                       input logic exp_m, input int exp_cnt,
                       input logic exp_d, input logic [1:0] exp_st);
    exp_t e;
    ip_valid = v;
    ip       = b;
    abort    = ab;
    if (exp_m) begin
      e = '{is_done: 1'b0, cyc: cyc + 1, st: 2'b00, cnt: exp_cnt};
      q.push_back(e);
    end
    if (exp_d) begin
      e = '{is_done: 1'b1, cyc: cyc + 1, st: exp_st, cnt: exp_cnt};
      q.push_back(e);
    end
    tick();
    ip_valid = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic run_s2(input logic gaps, input logic abort_last);
    for (int i = 0; i < 7; i++) begin
      if (abort_last && i == 6)
        drive(1'b1, 1'(s2_bits[i]), 1'b1, 1'b0, 1, 1'b1, ST_ABORT);
      else
        drive(1'b1, 1'(s2_bits[i]), 1'b0, s2_mcnt[i] != 0, s2_mcnt[i], i == 6, ST_TARGET);
      if (gaps && i != 6) drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, ST_NONE);
    end
    check("s2_done_busy", 32'(busy), 32'd0);
    check("s2_done_pulse", 32'(done), 32'd1);
    tick();
    check("s2_done_cleared", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; ip_valid = 1'b0; ip = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_pattern = '0; cfg_if.cfg_len = '0;
    cfg_if.cfg_target = '0; cfg_if.cfg_timeout = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check("rst_cfg_err", 32'(cfg_if.cfg_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);

    // Overlapping 10101 matches, target 2.
    configure(8'b0001_0101, 4'd5, 8'd2, 16'd0, 1'b0);
    check("s2_state_ready", 32'(dut.state), 32'(READY));
    start_run();
    run_s2(1'b0, 1'b0);

    // Same stream with idle gaps, then again with abort on the last bit.
    start_run();
    run_s2(1'b1, 1'b0);
    start_run();
    run_s2(1'b0, 1'b1);
    check("abort_status_hold", 32'(status), 32'(ST_ABORT));

    // Timeout of 10 cycles with a stream that never matches.
    configure(8'b0000_0110, 4'd3, 8'd0, 16'd10, 1'b0);
    start_run();
    begin
      exp_t e;
      e = '{is_done: 1'b1, cyc: cyc + 10, st: ST_TIMEOUT, cnt: 0};
      q.push_back(e);
    end
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, ST_NONE);

    // Invalid length drops to IDLE; start is ignored there.
    configure(8'hFF, 4'd0, 8'd3, 16'd0, 1'b1);
    check("bad_len_state", 32'(dut.state), 32'(IDLE));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_start_busy", 32'(busy), 32'd0);
    tick();
    check("idle_start_state", 32'(dut.state), 32'(IDLE));
    configure(8'hFF, 4'd8, 8'd3, 16'd0, 1'b0);
    check("good_len_state", 32'(dut.state), 32'(READY));

    // Full-length all-ones pattern: matches after bits 8, 9, 10.
    start_run();
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b1, 1'b0, i >= 7, (i >= 7) ? i - 6 : 0, i == 9, ST_TARGET);
    tick();
    check("s6_status_hold", 32'(status), 32'(ST_TARGET));
    check("s6_count_hold", 32'(match_count), 32'd3);

    // Reset in the middle of a run clears everything immediately.
    start_run();
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 1'b0, i == 7, 1, 1'b0, ST_NONE);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_match", 32'(match), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_status", 32'(status), 32'd0);
    check("mid_rst_count", 32'(match_count), 32'd0);
    check("mid_rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    tick();
    reset = 1'b0;
    tick();

    check("sb_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
